// File: rtl/ham_pkg.sv
// Shared constants, error classes and codeword position helpers for the SECDED Hamming decoder.
package ham_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int PARITY_BITS  = 6;
  localparam int ENCODED_WORD = DATA_WIDTH + PARITY_BITS;

  typedef enum logic [1:0] {ERR_NONE, ERR_SEC, ERR_DED} err_class_e;

  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // 1-based codeword position carrying data bit idx (data fills the non-power-of-2 slots, LSB first).
  function automatic int data_pos(input int idx);
    int n;
    int pos;
    n   = 0;
    pos = 0;
    for (int k = 1; k < 512; k++) begin
      if (!is_pow2(k)) begin
        if (n == idx && pos == 0) pos = k;
        n++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/ham_dec_lane.sv
// One decoder lane: syndrome/parity stage, correct/classify stage, saturating error counters.
// Latency 2 cycles; a stalled output holds and backpressures via o_ready. First-DED log only with HAM_DEC_SYN_LOG_EN.
module ham_dec_lane
  import ham_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PAR_W  = 6,
  parameter int CODE_W = 38,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [CODE_W+1:1] i_code,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_sec,
  output logic              o_ded,
  output logic [CNT_W-1:0]  o_sec_cnt,
  output logic [CNT_W-1:0]  o_ded_cnt,
  input  logic              i_clr_cnt,
  output logic [PAR_W:0]    o_syn_log
);

  logic              s1_vld_q;
  logic [PAR_W-1:0]  s1_syn_q, s1_syn_d;
  logic              s1_par_q, s1_par_d;
  logic [CODE_W+1:1] s1_code_q;
  logic              s2_vld_q;
  logic [DATA_W-1:0] s2_dat_q, s2_dat_d;
  logic              s2_sec_q, s2_sec_d;
  logic              s2_ded_q, s2_ded_d;
  logic [CNT_W-1:0]  sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0]  ded_cnt_q, ded_cnt_d;
  logic              s1_adv, s2_adv, out_hs;
  err_class_e        cls;
  logic [CODE_W+1:1] fixed;
  logic              unused_par;

  assign s2_adv  = !s2_vld_q || i_ready;
  assign s1_adv  = !s1_vld_q || s2_adv;
  assign o_ready = s1_adv;
  assign out_hs  = s2_vld_q && i_ready;

  always_comb begin
    s1_syn_d = '0;
    for (int k = 1; k <= CODE_W; k++) begin
      if (i_code[k]) s1_syn_d = s1_syn_d ^ PAR_W'(k);
    end
    s1_par_d = ^i_code;
  end

  // Odd overall parity means one flip (syndrome 0 = the overall bit itself); anything else nonzero is uncorrectable.
  always_comb begin
    cls = ERR_NONE;
    if (s1_par_q) begin
      if (s1_syn_q <= PAR_W'(CODE_W)) cls = ERR_SEC;
      else                            cls = ERR_DED;
    end else if (s1_syn_q != '0) begin
      cls = ERR_DED;
    end
  end

  always_comb begin
    fixed = s1_code_q;
    for (int k = 1; k <= CODE_W; k++) begin
      if (cls == ERR_SEC && s1_syn_q == PAR_W'(k)) fixed[k] = !s1_code_q[k];
    end
  end

  for (genvar i = 0; i < DATA_W; i++) begin : g_extract
    localparam int POS = data_pos(i);
    assign s2_dat_d[i] = fixed[POS];
  end

  always_comb begin
    unused_par = fixed[CODE_W+1];
    for (int k = 1; k <= CODE_W; k++) begin
      if (is_pow2(k)) unused_par = unused_par ^ fixed[k];
    end
  end

  assign s2_sec_d = (cls == ERR_SEC);
  assign s2_ded_d = (cls == ERR_DED);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_vld_q  <= 1'b0;
      s1_syn_q  <= '0;
      s1_par_q  <= 1'b0;
      s1_code_q <= '0;
    end else if (s1_adv) begin
      s1_vld_q <= i_valid;
      if (i_valid) begin
        s1_syn_q  <= s1_syn_d;
        s1_par_q  <= s1_par_d;
        s1_code_q <= i_code;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_vld_q <= 1'b0;
      s2_dat_q <= '0;
      s2_sec_q <= 1'b0;
      s2_ded_q <= 1'b0;
    end else if (s2_adv) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_dat_q <= s2_dat_d;
        s2_sec_q <= s2_sec_d;
        s2_ded_q <= s2_ded_d;
      end
    end
  end

  // Clear beats a same-cycle increment.
  always_comb begin
    sec_cnt_d = sec_cnt_q;
    ded_cnt_d = ded_cnt_q;
    if (i_clr_cnt) begin
      sec_cnt_d = '0;
      ded_cnt_d = '0;
    end else if (out_hs) begin
      if (s2_sec_q && sec_cnt_q != '1) sec_cnt_d = sec_cnt_q + CNT_W'(1);
      if (s2_ded_q && ded_cnt_q != '1) ded_cnt_d = ded_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else begin
      sec_cnt_q <= sec_cnt_d;
      ded_cnt_q <= ded_cnt_d;
    end
  end

`ifdef HAM_DEC_SYN_LOG_EN
  logic [PAR_W-1:0] s2_syn_q;
  logic [PAR_W:0]   log_q, log_d;

  always_ff @(posedge i_clk) begin
    if (i_rst)                    s2_syn_q <= '0;
    else if (s2_adv && s1_vld_q)  s2_syn_q <= s1_syn_q;
  end

  always_comb begin
    log_d = log_q;
    if (i_clr_cnt)                                    log_d = '0;
    else if (out_hs && s2_ded_q && !log_q[PAR_W])     log_d = {1'b1, s2_syn_q};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) log_q <= '0;
    else       log_q <= log_d;
  end

  assign o_syn_log = log_q;
`else
  assign o_syn_log = '0;
`endif

  assign o_valid   = s2_vld_q;
  assign o_data    = s2_dat_q;
  assign o_sec     = s2_sec_q;
  assign o_ded     = s2_ded_q;
  assign o_sec_cnt = sec_cnt_q;
  assign o_ded_cnt = ded_cnt_q;

endmodule

// File: rtl/ham_dec.sv
// Dual-port SECDED Hamming decoder: two independent 2-stage lanes (2-cycle latency, output stall backpressures
// through o_ready). Shared counter clear. Define HAM_DEC_SYN_LOG_EN to build the per-port first-DED syndrome log.
module ham_dec #(
  parameter int DATA_WIDTH   = ham_pkg::DATA_WIDTH,
  parameter int PARITY_BITS  = ham_pkg::PARITY_BITS,
  parameter int ENCODED_WORD = DATA_WIDTH + PARITY_BITS,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [ENCODED_WORD+1:1] i_code_a,
  input  logic [ENCODED_WORD+1:1] i_code_b,
  input  logic                    i_valid_a,
  input  logic                    i_valid_b,
  output logic                    o_ready_a,
  output logic                    o_ready_b,
  output logic [DATA_WIDTH-1:0]   o_data_a,
  output logic [DATA_WIDTH-1:0]   o_data_b,
  output logic                    o_valid_a,
  output logic                    o_valid_b,
  input  logic                    i_ready_a,
  input  logic                    i_ready_b,
  output logic                    o_sec_a,
  output logic                    o_sec_b,
  output logic                    o_ded_a,
  output logic                    o_ded_b,
  output logic [COUNT_WIDTH-1:0]  o_sec_cnt_a,
  output logic [COUNT_WIDTH-1:0]  o_sec_cnt_b,
  output logic [COUNT_WIDTH-1:0]  o_ded_cnt_a,
  output logic [COUNT_WIDTH-1:0]  o_ded_cnt_b,
  input  logic                    i_clr_cnt,
  output logic [PARITY_BITS:0]    o_syn_log_a,
  output logic [PARITY_BITS:0]    o_syn_log_b
);

  ham_dec_lane #(
    .DATA_W (DATA_WIDTH),
    .PAR_W  (PARITY_BITS),
    .CODE_W (ENCODED_WORD),
    .CNT_W  (COUNT_WIDTH)
  ) u_lane_a (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_code    (i_code_a),
    .i_valid   (i_valid_a),
    .o_ready   (o_ready_a),
    .o_data    (o_data_a),
    .o_valid   (o_valid_a),
    .i_ready   (i_ready_a),
    .o_sec     (o_sec_a),
    .o_ded     (o_ded_a),
    .o_sec_cnt (o_sec_cnt_a),
    .o_ded_cnt (o_ded_cnt_a),
    .i_clr_cnt (i_clr_cnt),
    .o_syn_log (o_syn_log_a)
  );

  ham_dec_lane #(
    .DATA_W (DATA_WIDTH),
    .PAR_W  (PARITY_BITS),
    .CODE_W (ENCODED_WORD),
    .CNT_W  (COUNT_WIDTH)
  ) u_lane_b (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_code    (i_code_b),
    .i_valid   (i_valid_b),
    .o_ready   (o_ready_b),
    .o_data    (o_data_b),
    .o_valid   (o_valid_b),
    .i_ready   (i_ready_b),
    .o_sec     (o_sec_b),
    .o_ded     (o_ded_b),
    .o_sec_cnt (o_sec_cnt_b),
    .o_ded_cnt (o_ded_cnt_b),
    .i_clr_cnt (i_clr_cnt),
    .o_syn_log (o_syn_log_b)
  );

endmodule
